bus_requester: RTL

- Per-master bus front end that sits directly upstream of the fixed-priority bus arbiter in the Canny edge-detector system.
- One instance per master (SRAM DMA, UART, test bench). It turns a client "start burst" command into a BREQn/BGNTn handshake.
- While granted, it drives one address/data beat per cycle, stalls when the grant is pre-empted, and drops the request when the burst completes.
- Bus encoding as used system-wide: BREQn and BGNTn are asserted = 1, despite the n suffix.

---
 rtl/bus_pkg.sv | 20 ++
 rtl/bus_beat_counter.sv | 28 ++
 rtl/bus_requester.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: requester FSM encoding, default widths
// and arbiter slot indices for the requester instances.
package bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 8;
  localparam int LW_DEF = 8;

  localparam int UNIT_SRAM = 0;
  localparam int UNIT_UART = 1;
  localparam int UNIT_TB   = 2;

endpackage

// File: rtl/bus_beat_counter.sv
// Loadable down-counter with a last flag (count == 1).
// Used for remaining beats and for the grant wait timeout.
module bus_beat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/bus_requester.sv
// Per-master BREQn/BGNTn bus front end: one beat per granted cycle.
// Optional grant-wait timeout enabled by macro REQ_TIMEOUT_EN.
module bus_requester
  import bus_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int LW      = LW_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [LW-1:0] burst_len,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  output logic          wr_pop,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          BREQn,
  input  logic          BGNTn,
  output logic          bus_oe,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata
);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic          wr_q;
  logic          breq_q;
  logic          rd_valid_q;
  logic [DW-1:0] rd_data_q;
  logic          accept;
  logic          beat;
  logic          len_last;
  logic          tmo_hit;

  assign accept = (state_q == S_IDLE) & start;
  assign beat   = (state_q == S_XFER) & BGNTn;

  bus_beat_counter #(.W(LW)) u_len (
    .clk      (CLK),
    .rst_n    (RSTn),
    .load     (accept),
    .load_val (burst_len),
    .dec      (beat),
    .last     (len_last)
  );

`ifdef REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic tmo_last;
  logic err_q;

  bus_beat_counter #(.W(TW)) u_tmo (
    .clk      (CLK),
    .rst_n    (RSTn),
    .load     (accept),
    .load_val (TW'(TIMEOUT)),
    .dec      ((state_q == S_REQ) & ~BGNTn),
    .last     (tmo_last)
  );

  // A grant in the expiry cycle wins over the timeout.
  assign tmo_hit = (state_q == S_REQ) & ~BGNTn & tmo_last;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      err_q <= 1'b0;
    end else if (state_q != S_FIN) begin
      err_q <= tmo_hit;
    end
  end

  assign err = (state_q == S_FIN) & err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (burst_len == '0) ? S_FIN : S_REQ;
        end
      end
      S_REQ: begin
        if (BGNTn) begin
          state_d = S_XFER;
        end else if (tmo_hit) begin
          state_d = S_FIN;
        end
      end
      S_XFER: begin
        if (beat && len_last) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      breq_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      breq_q     <= (state_d == S_REQ) | (state_d == S_XFER);
      rd_valid_q <= beat & ~wr_q;
      if (accept) begin
        addr_q <= start_addr;
        wr_q   <= wr;
      end else if (beat) begin
        addr_q <= addr_q + 1'b1;
      end
      if (beat && !wr_q) begin
        rd_data_q <= bus_rdata;
      end
    end
  end

  assign BREQn     = breq_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign bus_oe    = beat;
  assign bus_we    = beat & wr_q;
  assign wr_pop    = beat & wr_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule
